// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_issue_stage                                            |
// | Description : ID/EX stage feeding the 32-bit ALU. Decodes the ALU        |
// |               operation code, selects and (optionally) forwards the      |
// |               operands, and registers them behind a valid/ready          |
// |               handshake with stall and flush support.                    |
// | Options     : define ALU_ISSUE_FWD_EN to build the EX/MEM and MEM/WB     |
// |               forwarding network; without it the hazard unit stalls.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_issue_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              InValid,
   output logic              InReady,
   input  logic [XLEN-1:0]   PC,
   input  logic [31:0]       Instr,
   input  logic [XLEN-1:0]   RS1Data,
   input  logic [XLEN-1:0]   RS2Data,
   input  logic [XLEN-1:0]   Imm,
   input  logic [REG_AW-1:0] FwdRdEM,
   input  logic              FwdWeEM,
   input  logic [XLEN-1:0]   FwdDataEM,
   input  logic [REG_AW-1:0] FwdRdMW,
   input  logic              FwdWeMW,
   input  logic [XLEN-1:0]   FwdDataMW,
   input  logic              Flush,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [XLEN-1:0]   S1,
   output logic [XLEN-1:0]   S2,
   output logic [3:0]        ControlUnit,
   output logic [REG_AW-1:0] RdOut,
   output logic              IllegalOp
);

   // RV32I major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Operand-1 source select
   localparam logic [1:0] S1_SEL_RS1  = 2'd0;
   localparam logic [1:0] S1_SEL_PC   = 2'd1;
   localparam logic [1:0] S1_SEL_ZERO = 2'd2;

   // Instruction fields
   logic [6:0]        opcode;
   logic [2:0]        f3;
   logic              f7b;
   logic [REG_AW-1:0] rs1_idx;
   logic [REG_AW-1:0] rs2_idx;
   logic [REG_AW-1:0] rd_idx;

   assign opcode  = Instr[6:0];
   assign f3      = Instr[14:12];
   assign f7b     = Instr[30];
   assign rs1_idx = REG_AW'(Instr[19:15]);
   assign rs2_idx = REG_AW'(Instr[24:20]);
   assign rd_idx  = REG_AW'(Instr[11:7]);

   // Pipeline registers
   logic              valid_q,   valid_d;
   logic [XLEN-1:0]   s1_q,      s1_d;
   logic [XLEN-1:0]   s2_q,      s2_d;
   logic [3:0]        cu_q,      cu_d;
   logic [REG_AW-1:0] rd_q,      rd_d;
   logic              illegal_q, illegal_d;

   // Decode / operand values
   logic [3:0]      dec_cu;
   logic            dec_illegal;
   logic [1:0]      dec_s1_sel;
   logic            dec_s2_rs2;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            accept;
   logic            consume;

   // Unread instruction bits (funct7 apart from bit 30)
   logic unused_instr;
   assign unused_instr = ^{Instr[31], Instr[29:25]};

   assign InReady = !valid_q || OutReady;
   assign accept  = InValid && InReady;
   assign consume = valid_q && OutReady;

   // Opcode decode: ALU code, illegal flag and operand routing
   always_comb begin
      dec_cu      = 4'b0000;
      dec_illegal = 1'b0;
      dec_s1_sel  = S1_SEL_RS1;
      dec_s2_rs2  = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_cu     = {f7b, f3};
            dec_s2_rs2 = 1'b1;
         end
         // Bit 30 only distinguishes SRAI from SRLI among the immediate ops
         OPC_OP_IMM:                      dec_cu     = {f7b & (f3 == 3'b101), f3};
         OPC_LOAD, OPC_STORE, OPC_JALR:   dec_s1_sel = S1_SEL_RS1;
         OPC_AUIPC, OPC_BRANCH, OPC_JAL:  dec_s1_sel = S1_SEL_PC;
         OPC_LUI:                         dec_s1_sel = S1_SEL_ZERO;
         default:                         dec_illegal = 1'b1;
      endcase
   end

`ifdef ALU_ISSUE_FWD_EN
   // Bypass the register file from EX/MEM (youngest) then MEM/WB; x0 never bypassed
   always_comb begin
      rs1_val = RS1Data;
      rs2_val = RS2Data;
      if (rs1_idx != '0) begin
         if (FwdWeEM && (FwdRdEM == rs1_idx))      rs1_val = FwdDataEM;
         else if (FwdWeMW && (FwdRdMW == rs1_idx)) rs1_val = FwdDataMW;
      end
      if (rs2_idx != '0) begin
         if (FwdWeEM && (FwdRdEM == rs2_idx))      rs2_val = FwdDataEM;
         else if (FwdWeMW && (FwdRdMW == rs2_idx)) rs2_val = FwdDataMW;
      end
   end
`else
   // No bypass network: register-file data is used as-is, hazards are stalled upstream
   assign rs1_val = RS1Data;
   assign rs2_val = RS2Data;

   logic unused_fwd;
   assign unused_fwd = ^{FwdRdEM, FwdWeEM, FwdDataEM, FwdRdMW, FwdWeMW, FwdDataMW,
                         rs1_idx, rs2_idx};
`endif

   // Operand select
   always_comb begin
      op1 = rs1_val;
      case (dec_s1_sel)
         S1_SEL_PC:   op1 = PC;
         S1_SEL_ZERO: op1 = '0;
         default:     op1 = rs1_val;
      endcase
      op2 = dec_s2_rs2 ? rs2_val : Imm;
   end

   // Next slot: flush kills everything, accept loads, consume empties, else hold
   always_comb begin
      valid_d   = valid_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      cu_d      = cu_q;
      rd_d      = rd_q;
      illegal_d = illegal_q;
      if (Flush) begin
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         s1_d      = op1;
         s2_d      = op2;
         cu_d      = dec_cu;
         rd_d      = rd_idx;
         illegal_d = dec_illegal;
      end else if (consume) begin
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end
   end

   // Slot registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         cu_q      <= 4'b0000;
         rd_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         cu_q      <= cu_d;
         rd_q      <= rd_d;
         illegal_q <= illegal_d;
      end
   end

   assign OutValid    = valid_q;
   assign S1          = s1_q;
   assign S2          = s2_q;
   assign ControlUnit = cu_q;
   assign RdOut       = rd_q;
   assign IllegalOp   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_issue_stage                                         |
// | Description : Self-checking bench for alu_issue_stage: directed slots    |
// |               with literal expectations plus a per-cycle reference model.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_issue_stage;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              InValid;
   logic              InReady;
   logic [XLEN-1:0]   PC;
   logic [31:0]       Instr;
   logic [XLEN-1:0]   RS1Data;
   logic [XLEN-1:0]   RS2Data;
   logic [XLEN-1:0]   Imm;
   logic [REG_AW-1:0] FwdRdEM;
   logic              FwdWeEM;
   logic [XLEN-1:0]   FwdDataEM;
   logic [REG_AW-1:0] FwdRdMW;
   logic              FwdWeMW;
   logic [XLEN-1:0]   FwdDataMW;
   logic              Flush;
   logic              OutValid;
   logic              OutReady;
   logic [XLEN-1:0]   S1;
   logic [XLEN-1:0]   S2;
   logic [3:0]        ControlUnit;
   logic [REG_AW-1:0] RdOut;
   logic              IllegalOp;

   int n_total = 0;
   int n_pass  = 0;

   alu_issue_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst),
      .InValid(InValid), .InReady(InReady),
      .PC(PC), .Instr(Instr), .RS1Data(RS1Data), .RS2Data(RS2Data), .Imm(Imm),
      .FwdRdEM(FwdRdEM), .FwdWeEM(FwdWeEM), .FwdDataEM(FwdDataEM),
      .FwdRdMW(FwdRdMW), .FwdWeMW(FwdWeMW), .FwdDataMW(FwdDataMW),
      .Flush(Flush),
      .OutValid(OutValid), .OutReady(OutReady),
      .S1(S1), .S2(S2), .ControlUnit(ControlUnit), .RdOut(RdOut), .IllegalOp(IllegalOp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_known(input logic [6:0] opc);
      return opc inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};
   endfunction

   function automatic logic [3:0] ref_cu(input logic [31:0] ins);
      if (ins[6:0] == 7'h33) return {ins[30], ins[14:12]};
      if (ins[6:0] == 7'h13) return {(ins[14:12] == 3'd5) ? ins[30] : 1'b0, ins[14:12]};
      return 4'd0;
   endfunction

   function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] raw);
`ifdef ALU_ISSUE_FWD_EN
      if (idx == 0) return raw;
      if (FwdWeEM && FwdRdEM == idx) return FwdDataEM;
      if (FwdWeMW && FwdRdMW == idx) return FwdDataMW;
`endif
      return raw;
   endfunction

   function automatic logic [31:0] ref_s1(input logic [31:0] ins);
      if (ins[6:0] == 7'h37) return 32'd0;
      if (ins[6:0] inside {7'h17, 7'h63, 7'h6f}) return PC;
      return reg_value(ins[19:15], RS1Data);
   endfunction

   function automatic logic [31:0] ref_s2(input logic [31:0] ins);
      if (ins[6:0] == 7'h33) return reg_value(ins[24:20], RS2Data);
      return Imm;
   endfunction

   logic        m_valid;
   logic [31:0] m_s1, m_s2;
   logic [3:0]  m_cu;
   logic [4:0]  m_rd;
   logic        m_ill;

   // Model state advances on the same edges as the DUT
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0; m_s1 = 0; m_s2 = 0; m_cu = 0; m_rd = 0; m_ill = 0;
      end else if (Flush) begin
         m_valid = 0; m_ill = 0;
      end else if (InValid && (!m_valid || OutReady)) begin
         m_valid = 1;
         m_s1    = ref_s1(Instr);
         m_s2    = ref_s2(Instr);
         m_cu    = ref_cu(Instr);
         m_rd    = Instr[11:7];
         m_ill   = !is_known(Instr[6:0]);
      end else if (m_valid && OutReady) begin
         m_valid = 0; m_ill = 0;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         check("model_in_ready", 32'(InReady), 32'(!m_valid || OutReady));
         check("model_out_valid", 32'(OutValid), 32'(m_valid));
         if (m_valid) begin
            check("model_s1", S1, m_s1);
            check("model_s2", S2, m_s2);
            check("model_cu", 32'(ControlUnit), 32'(m_cu));
            check("model_rd", 32'(RdOut), 32'(m_rd));
            check("model_illegal", 32'(IllegalOp), 32'(m_ill));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic slot(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
      PC = pc; Instr = ins; RS1Data = r1; RS2Data = r2; Imm = imm;
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1; InValid = 0; OutReady = 1; Flush = 0;
      PC = 0; Instr = 0; RS1Data = 0; RS2Data = 0; Imm = 0;
      FwdRdEM = 0; FwdWeEM = 0; FwdDataEM = 0; FwdRdMW = 0; FwdWeMW = 0; FwdDataMW = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(OutValid), 0);
      check("rst_s1", S1, 0);
      check("rst_s2", S2, 0);
      check("rst_cu", 32'(ControlUnit), 0);
      check("rst_rd", 32'(RdOut), 0);
      check("rst_illegal", 32'(IllegalOp), 0);
      rst = 0;

      // sub x3,x1,x2
      InValid = 1;
      slot(32'h100, 32'h402081B3, 10, 3, 32'h0);
      tick;
      check("sub_valid", 32'(OutValid), 1);
      check("sub_s1", S1, 10);
      check("sub_s2", S2, 3);
      check("sub_cu", 32'(ControlUnit), 4'b1000);
      check("sub_rd", 32'(RdOut), 3);

      // srai x5,x6,4 then the same encoding as addi
      slot(32'h104, 32'h40435293, 32'h80000000, 7, 32'h404);
      tick;
      check("srai_cu", 32'(ControlUnit), 4'b1101);
      check("srai_s1", S1, 32'h80000000);
      check("srai_s2", S2, 32'h404);
      slot(32'h108, 32'h40430293, 32'h80000000, 7, 32'h404);
      tick;
      check("addi_cu", 32'(ControlUnit), 4'b0000);

      // forwarding priority: add x3,x1,x2 with both stages writing x1
      slot(32'h10c, 32'h002081B3, 32'h11, 32'h22, 0);
      FwdWeEM = 1; FwdRdEM = 1; FwdDataEM = 32'h55;
      FwdWeMW = 1; FwdRdMW = 1; FwdDataMW = 32'h66;
      tick;
`ifdef ALU_ISSUE_FWD_EN
      check("fwd_em_s1", S1, 32'h55);
`else
      check("fwd_em_s1", S1, 32'h11);
`endif
      FwdWeEM = 0;
      tick;
`ifdef ALU_ISSUE_FWD_EN
      check("fwd_mw_s1", S1, 32'h66);
`else
      check("fwd_mw_s1", S1, 32'h11);
`endif
      // add x3,x0,x2 : x0 never forwarded
      slot(32'h110, 32'h002001B3, 32'h11, 32'h22, 0);
      FwdWeEM = 1; FwdRdEM = 0; FwdWeMW = 0;
      tick;
      check("fwd_x0_s1", S1, 32'h11);
      FwdWeEM = 0;

      // FENCE is not an ALU opcode
      slot(32'h114, 32'h0000000F, 1, 2, 3);
      tick;
      check("fence_valid", 32'(OutValid), 1);
      check("fence_illegal", 32'(IllegalOp), 1);
      check("fence_cu", 32'(ControlUnit), 0);

      // AUIPC x1
      slot(32'h1000, 32'h00002097, 32'h77, 32'h88, 32'h2000);
      tick;
      check("auipc_s1", S1, 32'h1000);
      check("auipc_s2", S2, 32'h2000);
      check("auipc_cu", 32'(ControlUnit), 0);
      check("auipc_illegal", 32'(IllegalOp), 0);

      // LUI x5
      slot(32'h1004, 32'h123452B7, 32'h77, 32'h88, 32'h12345000);
      tick;
      check("lui_s1", S1, 0);
      check("lui_s2", S2, 32'h12345000);

      // drain, then hold a slot under back-pressure
      InValid = 0;
      tick;
      check("drain_valid", 32'(OutValid), 0);
      InValid = 1; OutReady = 0;
      slot(32'h200, 32'h402081B3, 10, 3, 0);
      tick;
      check("stall_valid", 32'(OutValid), 1);
      for (int i = 0; i < 3; i++) begin
         slot(32'h300 + 32'(i), 32'h40435293, 32'hA0 + 32'(i), 32'hB0, 32'hC0);
         tick;
         check("stall_in_ready", 32'(InReady), 0);
         check("stall_s1", S1, 10);
         check("stall_s2", S2, 3);
         check("stall_cu", 32'(ControlUnit), 4'b1000);
      end
      // release: new slot captured on the same edge
      OutReady = 1;
      slot(32'h1000, 32'h00002097, 0, 0, 32'h2000);
      tick;
      check("release_valid", 32'(OutValid), 1);
      check("release_s1", S1, 32'h1000);

      // flush beats a simultaneous accept
      slot(32'h400, 32'h0000000F, 0, 0, 0);
      tick;
      Flush = 1;
      slot(32'h404, 32'h0000000F, 0, 0, 0);
      tick;
      check("flush_valid", 32'(OutValid), 0);
      check("flush_illegal", 32'(IllegalOp), 0);
      Flush = 0;

      // asynchronous reset mid-cycle
      slot(32'h500, 32'h402081B3, 10, 3, 0);
      tick;
      check("pre_rst_valid", 32'(OutValid), 1);
      rst = 1;
      #1;
      check("async_rst_valid", 32'(OutValid), 0);
      check("async_rst_s1", S1, 0);
      check("async_rst_cu", 32'(ControlUnit), 0);
      check("async_rst_rd", 32'(RdOut), 0);
      @(posedge clk);
      #1;
      rst = 0;
      InValid = 0;
      repeat (2) tick;
      check("post_rst_valid", 32'(OutValid), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
